// File: rtl/room_cmd_scheduler.sv
// Round-robin scheduler sharing the draw datapath and audio player among the room command sources.
// Define SCHED_AUDIO_EN to add the audio phase after each draw; otherwise a command ends at draw_done.
module room_cmd_scheduler #(
  parameter int unsigned NUM_ROOMS = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic [NUM_ROOMS-1:0] i_req,
  input  logic [NUM_ROOMS-1:0] i_req_funct,
  input  logic [NUM_ROOMS-1:0] i_req_on,
  input  logic                 i_draw_done,
  input  logic                 i_aud_done,
  output logic [2:0]           o_grant_room,
  output logic                 o_grant_funct,
  output logic                 o_grant_on,
  output logic                 o_draw_start,
  output logic                 o_aud_start,
  output logic [NUM_ROOMS-1:0] o_pending,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StDraw,
    StWaitDraw,
    StAud,
    StWaitAud
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [NUM_ROOMS-1:0] r_pending;
  logic [NUM_ROOMS-1:0] r_funct;
  logic [NUM_ROOMS-1:0] r_on;
  logic [NUM_ROOMS-1:0] w_grant_clr;
  logic [2:0]           r_last_grant;
  logic [2:0]           r_grant_room;
  logic                 r_grant_funct;
  logic                 r_grant_on;
  logic [2:0]           w_pick;
  logic [3:0]           w_idx;
  logic                 w_found;
  logic                 w_arb_hit;

  // Search starts one past the last grant and wraps, so every room gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= int'(NUM_ROOMS); k++) begin
      w_idx = {1'b0, r_last_grant} + 4'(k);
      if (w_idx >= 4'(NUM_ROOMS)) begin
        w_idx = w_idx - 4'(NUM_ROOMS);
      end
      if (!w_found && r_pending[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[2:0];
      end
    end
  end

  assign w_arb_hit = (r_state == StArb) && w_found;

  always_comb begin
    w_grant_clr = '0;
    for (int i = 0; i < int'(NUM_ROOMS); i++) begin
      w_grant_clr[i] = w_arb_hit && (w_pick == 3'(i));
    end
  end

  // A fresh request outranks both the grant-clear and the flush.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pending <= '0;
      r_funct   <= '0;
      r_on      <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_ROOMS); i++) begin
        if (i_req[i]) begin
          r_pending[i] <= 1'b1;
          r_funct[i]   <= i_req_funct[i];
          r_on[i]      <= i_req_on[i];
        end else if (w_grant_clr[i] || i_clear) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_grant  <= 3'(NUM_ROOMS - 1);
      r_grant_room  <= '0;
      r_grant_funct <= 1'b0;
      r_grant_on    <= 1'b0;
    end else if (w_arb_hit) begin
      r_last_grant  <= w_pick;
      r_grant_room  <= w_pick;
      r_grant_funct <= r_funct[w_pick];
      r_grant_on    <= r_on[w_pick];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:     if (|r_pending) w_state_next = StArb;
      StArb:      w_state_next = w_found ? StDraw : StIdle;
      StDraw:     w_state_next = StWaitDraw;
`ifdef SCHED_AUDIO_EN
      StWaitDraw: if (i_draw_done) w_state_next = StAud;
      StAud:      w_state_next = StWaitAud;
      StWaitAud:  if (i_aud_done) w_state_next = StIdle;
`else
      StWaitDraw: if (i_draw_done) w_state_next = StIdle;
`endif
      default:    w_state_next = StIdle;
    endcase
  end

  assign o_grant_room  = r_grant_room;
  assign o_grant_funct = r_grant_funct;
  assign o_grant_on    = r_grant_on;
  assign o_pending     = r_pending;
  assign o_draw_start  = (r_state == StDraw);
  assign o_busy        = (r_state != StIdle);

`ifdef SCHED_AUDIO_EN
  assign o_aud_start = (r_state == StAud);
`else
  logic w_unused_aud_done;
  assign w_unused_aud_done = i_aud_done;
  assign o_aud_start       = 1'b0;
`endif

endmodule

// File: tb/tb_room_cmd_scheduler.sv
// Self-checking bench for room_cmd_scheduler: directed scenarios plus a randomized run
// against a cycle-level reference model.
module tb_room_cmd_scheduler;

  localparam int N = 5;
`ifdef SCHED_AUDIO_EN
  localparam bit AUD = 1'b1;
`else
  localparam bit AUD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, clr, dd, ad;
  logic [N-1:0] req, rf, ron;
  logic [2:0]   g_room;
  logic         g_fn, g_on, ds, as_, busy;
  logic [N-1:0] pend;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_ds  = 0;
  int cnt_as  = 0;

  // Reference model: pending set, round-robin pointer and the phase of the command in service
  // (0 idle, 1 choosing, 2 draw pulse, 3 awaiting draw, 4 audio pulse, 5 awaiting audio).
  logic [N-1:0] m_pend, m_fn, m_on;
  int           m_last, m_room, m_step;
  logic         m_gf, m_go;

  always #5 clk = ~clk;

  room_cmd_scheduler #(.NUM_ROOMS(N)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_clear      (clr),
    .i_req        (req),
    .i_req_funct  (rf),
    .i_req_on     (ron),
    .i_draw_done  (dd),
    .i_aud_done   (ad),
    .o_grant_room (g_room),
    .o_grant_funct(g_fn),
    .o_grant_on   (g_on),
    .o_draw_start (ds),
    .o_aud_start  (as_),
    .o_pending    (pend),
    .o_busy       (busy)
  );

  always @(posedge clk) begin
    if (ds === 1'b1) cnt_ds++;
    if (as_ === 1'b1) cnt_as++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pend = '0; m_fn = '0; m_on = '0;
    m_last = N - 1; m_room = 0; m_gf = 1'b0; m_go = 1'b0; m_step = 0;
  endtask

  task automatic model_step();
    int g = -1;
    int nstep;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_step == 1) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (g < 0 && m_pend[idx]) g = idx;
      end
    end
    case (m_step)
      0:       nstep = (m_pend != 0) ? 1 : 0;
      1:       nstep = (g >= 0) ? 2 : 0;
      2:       nstep = 3;
      3:       nstep = dd ? (AUD ? 4 : 0) : 3;
      4:       nstep = 5;
      default: nstep = ad ? 0 : 5;
    endcase
    if (g >= 0) begin
      m_room = g; m_gf = m_fn[g]; m_go = m_on[g]; m_last = g;
    end
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        m_pend[i] = 1'b1; m_fn[i] = rf[i]; m_on[i] = ron[i];
      end else if (i == g || clr) begin
        m_pend[i] = 1'b0;
      end
    end
    m_step = nstep;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; req = '0; rf = '0; ron = '0; dd = 1'b0; ad = 1'b0;
    cyc();
    rst = 1'b0;
    model_reset();
  endtask

  // Returns cycles waited until draw_start is seen, or -1 if the budget runs out.
  task automatic wait_draw(input int budget, output int waited);
    waited = -1;
    for (int c = 0; c < budget; c++) begin
      if (ds === 1'b1) begin
        waited = c;
        return;
      end
      cyc();
    end
  endtask

  // Called while draw_start is high; completes the command with one-cycle done latencies.
  task automatic finish_cmd();
    cyc();
    dd = 1'b1; cyc(); dd = 1'b0;
    cyc();
    ad = 1'b1; cyc(); ad = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; dd = 1'b0; ad = 1'b0;
    req = '1; rf = '1; ron = '1;
    cyc(); cyc();
    n_tests++;
    if (pend !== '0) begin
      n_fail++; $display("FAIL reset_pending: got %b expected 0", pend);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_tests++;
    if ({g_room, g_fn, g_on} !== 5'b0) begin
      n_fail++; $display("FAIL reset_grant: got room=%0d fn=%b on=%b expected 0/0/0", g_room, g_fn, g_on);
    end
    n_tests++;
    if ({ds, as_} !== 2'b00) begin
      n_fail++; $display("FAIL reset_starts: got ds=%b as=%b expected 0/0", ds, as_);
    end
    rst = 1'b0; req = '0; rf = '0; ron = '0;
    cyc(); cyc();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_after: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 5'b00100; rf = 5'b00100; ron = 5'b00100;
    cyc();
    req = '0; rf = '0; ron = '0;
    n_tests++;
    if (pend !== 5'b00100 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_capture: got pend=%b busy=%b expected 00100/0", pend, busy);
    end
    cyc();
    n_tests++;
    if (busy !== 1'b1 || ds !== 1'b0) begin
      n_fail++; $display("FAIL single_arb: got busy=%b ds=%b expected 1/0", busy, ds);
    end
    cyc();
    n_tests++;
    if ({ds, g_room, g_fn, g_on} !== {1'b1, 3'd2, 1'b1, 1'b1} || pend !== '0) begin
      n_fail++;
      $display("FAIL single_draw: got ds=%b room=%0d fn=%b on=%b pend=%b expected 1/2/1/1/0",
               ds, g_room, g_fn, g_on, pend);
    end
    cyc();
    dd = 1'b1; cyc(); dd = 1'b0;
    n_tests++;
    if (as_ !== AUD || ds !== 1'b0) begin
      n_fail++; $display("FAIL single_aud_start: got as=%b ds=%b expected %b/0", as_, ds, AUD);
    end
    cyc();
    n_tests++;
    if (busy !== AUD) begin
      n_fail++; $display("FAIL single_wait_aud: got busy=%b expected %b", busy, AUD);
    end
    ad = 1'b1; cyc(); ad = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_all_rooms();
    logic [N-1:0] exp_fn, exp_on;
    int base_ds, base_as, w;
    do_reset();
    exp_fn = N'($urandom); exp_on = N'($urandom);
    req = '1; rf = exp_fn; ron = exp_on;
    cyc();
    req = '0; rf = '0; ron = '0;
    base_ds = cnt_ds; base_as = cnt_as;
    for (int r = 0; r < N; r++) begin
      wait_draw(20, w);
      n_tests++;
      if (w < 0) begin
        n_fail++; $display("FAIL all_rooms_timeout: no draw_start for room %0d", r);
      end else if ({g_room, g_fn, g_on} !== {3'(r), exp_fn[r], exp_on[r]}) begin
        n_fail++;
        $display("FAIL all_rooms_grant: got room=%0d fn=%b on=%b expected %0d/%b/%b",
                 g_room, g_fn, g_on, r, exp_fn[r], exp_on[r]);
      end
      finish_cmd();
    end
    repeat (8) cyc();
    n_tests++;
    if (cnt_ds - base_ds != N || cnt_as - base_as != (AUD ? N : 0)) begin
      n_fail++;
      $display("FAIL all_rooms_pulses: got draw=%0d aud=%0d expected %0d/%0d",
               cnt_ds - base_ds, cnt_as - base_as, N, AUD ? N : 0);
    end
    n_tests++;
    if (busy !== 1'b0 || pend !== '0) begin
      n_fail++; $display("FAIL all_rooms_end: got busy=%b pend=%b expected 0/0", busy, pend);
    end
  endtask

  task automatic test_latest_wins();
    int base_ds, w;
    do_reset();
    base_ds = cnt_ds;
    req = 5'b01000; rf = 5'b01000; ron = 5'b00000;
    cyc();
    rf = 5'b00000; ron = 5'b01000;
    cyc();
    req = '0; rf = '0; ron = '0;
    wait_draw(10, w);
    n_tests++;
    if (w < 0 || {g_room, g_fn, g_on} !== {3'd3, 1'b0, 1'b1} || pend !== '0) begin
      n_fail++;
      $display("FAIL latest_wins: got wait=%0d room=%0d fn=%b on=%b pend=%b expected 3/0/1/0",
               w, g_room, g_fn, g_on, pend);
    end
    finish_cmd();
    repeat (6) cyc();
    n_tests++;
    if (cnt_ds - base_ds != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latest_single_grant: got draws=%0d busy=%b expected 1/0", cnt_ds - base_ds, busy);
    end
  endtask

  task automatic test_clear();
    int base_ds, w;
    do_reset();
    req = 5'b00001;
    cyc();
    req = '0;
    wait_draw(10, w);
    cyc();
    req = 5'b10010;
    cyc();
    req = '0;
    n_tests++;
    if (pend !== 5'b10010) begin
      n_fail++; $display("FAIL clear_pre: got pend=%b expected 10010", pend);
    end
    clr = 1'b1; cyc(); clr = 1'b0;
    n_tests++;
    if (pend !== '0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL clear_flush: got pend=%b busy=%b expected 0/1", pend, busy);
    end
    base_ds = cnt_ds;
    dd = 1'b1; cyc(); dd = 1'b0;
    n_tests++;
    if (as_ !== AUD) begin
      n_fail++; $display("FAIL clear_aud_continues: got as=%b expected %b", as_, AUD);
    end
    cyc();
    ad = 1'b1; cyc(); ad = 1'b0;
    repeat (8) cyc();
    n_tests++;
    if (cnt_ds != base_ds || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_no_grant: got extra draws=%0d busy=%b expected 0/0", cnt_ds - base_ds, busy);
    end
  endtask

  task automatic test_regrant();
    int w;
    do_reset();
    req = 5'b00100;
    cyc();
    req = '0;
    cyc();
    req = 5'b00100;
    cyc();
    req = '0;
    n_tests++;
    if (ds !== 1'b1 || g_room !== 3'd2 || pend !== 5'b00100) begin
      n_fail++;
      $display("FAIL regrant_keep: got ds=%b room=%0d pend=%b expected 1/2/00100", ds, g_room, pend);
    end
    finish_cmd();
    wait_draw(12, w);
    n_tests++;
    if (w < 0 || g_room !== 3'd2) begin
      n_fail++; $display("FAIL regrant_again: got wait=%0d room=%0d expected room 2", w, g_room);
    end
    finish_cmd();
    repeat (6) cyc();
    n_tests++;
    if (busy !== 1'b0 || pend !== '0) begin
      n_fail++; $display("FAIL regrant_end: got busy=%b pend=%b expected 0/0", busy, pend);
    end
  endtask

  task automatic test_reset_mid();
    int base_ds, base_as, w;
    do_reset();
    req = 5'b00001;
    cyc();
    req = '0;
    wait_draw(10, w);
    cyc();
    req = 5'b00010;
    cyc();
    req = '0;
    dd = 1'b1; cyc(); dd = 1'b0;
    cyc();
    n_tests++;
    if (pend !== 5'b00010 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_pre: got pend=%b busy=%b expected 00010/1", pend, busy);
    end
    rst = 1'b1; req = 5'b00100;
    cyc();
    rst = 1'b0; req = '0;
    n_tests++;
    if (pend !== '0 || busy !== 1'b0 || ds !== 1'b0 || as_ !== 1'b0 || g_room !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_post: got pend=%b busy=%b ds=%b as=%b room=%0d expected 0/0/0/0/0",
               pend, busy, ds, as_, g_room);
    end
    base_ds = cnt_ds; base_as = cnt_as;
    repeat (4) cyc();
    n_tests++;
    if (cnt_ds != base_ds || cnt_as != base_as || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got draws=%0d auds=%0d busy=%b expected 0/0/0",
               cnt_ds - base_ds, cnt_as - base_as, busy);
    end
  endtask

  task automatic test_random(input int cycles);
    int base_ds;
    do_reset();
    base_ds = cnt_ds;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(5) == 0);
      rf  = N'($urandom);
      ron = N'($urandom);
      clr = ($urandom_range(31) == 0);
      dd  = ($urandom_range(2) == 0);
      ad  = ($urandom_range(2) == 0);
      rst = ($urandom_range(255) == 0);
      n_tests++;
      if ({pend, g_room, g_fn, g_on, ds, as_, busy} !==
          {m_pend, 3'(m_room), m_gf, m_go, m_step == 2, AUD && m_step == 4, m_step != 0}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got pend=%b room=%0d fn=%b on=%b ds=%b as=%b busy=%b expected pend=%b room=%0d fn=%b on=%b phase=%0d",
                 c, pend, g_room, g_fn, g_on, ds, as_, busy, m_pend, m_room, m_gf, m_go, m_step);
      end
      @(posedge clk);
      model_step();
      #1;
    end
    rst = 1'b0; clr = 1'b0; req = '0; dd = 1'b0; ad = 1'b0;
    n_tests++;
    if (cnt_ds - base_ds < 20) begin
      n_fail++; $display("FAIL random_progress: got %0d draws expected at least 20", cnt_ds - base_ds);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_rooms();
    test_latest_wins();
    test_clear();
    test_regrant();
    test_reset_mid();
    test_random(2000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
